// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   - fetch_state_t : sequencer states (two-byte fetch, execute, halt)
//   - ADDR_W_DEFAULT / INSTR_W_DEFAULT : default widths
//   - RESET_PC : program counter value loaded while reset is asserted
package fetch_pkg;

  localparam int ADDR_W_DEFAULT  = 8;
  localparam int INSTR_W_DEFAULT = 16;
  localparam int RESET_PC        = 0;

  typedef enum logic [2:0] {
    F0,      // read high byte
    F1,      // capture high byte, read low byte
    F2,      // capture low byte, advance PC by two
    EXEC,    // datapath owns memory until exec_done
    HALTED   // parked until reset
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer.
// Fetches a two-byte instruction (high byte first) from shared byte memory,
// hands it to the datapath, then waits for exec_done before fetching again.
// The PC register is an external sibling that loads next_address every edge.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   current_address     PC register output
//   next_address        value the PC register loads on the next edge
//   mem_addr, mem_rd    shared-memory read request (data returns next cycle)
//   mem_rdata           read data
//   bus_grant           datapath owns shared memory (EXEC)
//   instr, instr_valid  latched instruction and its valid flag
//   exec_done           datapath finished; qualifies branch_* and halt_req
//   branch_taken/target PC redirect applied with exec_done
//   halt_req            park in HALTED after this instruction
//   halted              sequencer is in HALTED
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int INSTR_W = INSTR_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  current_address,
  output logic [ADDR_W-1:0]  next_address,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [7:0]         mem_rdata,
  output logic               bus_grant,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt_req,
  output logic               halted
);

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path
    // through the case statement leaves a signal unassigned (no latches).
    state_d      = state_q;
    instr_d      = instr_q;
    next_address = current_address;
    mem_addr     = '0;
    mem_rd       = 1'b0;
    bus_grant    = 1'b0;
    instr_valid  = 1'b0;
    halted       = 1'b0;

    if (reset) begin
      // Reset overrides the outputs in the same cycle and abandons any
      // in-flight fetch; the PC sibling loads RESET_PC on this edge.
      state_d      = F0;
      instr_d      = '0;
      next_address = ADDR_W'(RESET_PC);
    end else begin
      unique case (state_q)
        F0: begin
          mem_addr = current_address;
          mem_rd   = 1'b1;
          state_d  = F1;
        end
        F1: begin
          // Data for the F0 read is valid now.
          instr_d[INSTR_W-1 -: 8] = mem_rdata;
          mem_addr = current_address + ADDR_W'(1);
          mem_rd   = 1'b1;
          state_d  = F2;
        end
        F2: begin
          instr_d[7:0] = mem_rdata;
          next_address = current_address + ADDR_W'(2);
          state_d      = EXEC;
        end
        EXEC: begin
          instr_valid = 1'b1;
          bus_grant   = 1'b1;
          if (exec_done) begin
            // Branch is applied even when halting on the same cycle.
            if (branch_taken) next_address = branch_target;
            state_d = halt_req ? HALTED : F0;
          end
        end
        HALTED: begin
          halted = 1'b1;
        end
        default: begin
          state_d = F0;
        end
      endcase
    end
  end

  // NOTE: reset is synchronous and already folded into the _d values above,
  // so this block is plain non-blocking register transfer with no reset branch.
  always_ff @(posedge clock) begin
    state_q <= state_d;
    instr_q <= instr_d;
  end

  assign instr = instr_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory/PC address width (256 byte locations).
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width (two bytes, high byte first).
REQ-003 SHALL have port: clock  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: current_address  input  ADDR_W  PC register output.
REQ-006 SHALL have port: next_address  output  ADDR_W  value the PC register loads on every rising edge.
REQ-007 SHALL have port: mem_addr  output  ADDR_W  shared-memory read address during fetch.
REQ-008 SHALL have port: mem_rd  output  1  shared-memory read strobe.
REQ-009 SHALL have port: mem_rdata  input  8  read data, valid one cycle after mem_rd.
REQ-010 SHALL have port: bus_grant  output  1  datapath owns shared memory.
REQ-011 SHALL have port: instr  output  INSTR_W  latched instruction.
REQ-012 SHALL have port: instr_valid  output  1  instr valid for execute.
REQ-013 SHALL have port: exec_done  input  1  datapath finished current instruction.
REQ-014 SHALL have port: branch_taken  input  1  redirect PC; sampled with exec_done.
REQ-015 SHALL have port: branch_target  input  ADDR_W  redirect address; sampled with exec_done.
REQ-016 SHALL have port: halt_req  input  1  stop after current instruction; sampled with exec_done.
REQ-017 SHALL have port: halted  output  1  sequencer in HALTED.

Function
REQ-018 SHALL implement states F0, F1, F2, EXEC, HALTED.
REQ-019 SHALL, in F0, drive mem_addr=current_address, mem_rd=1, next_address=current_address; go to F1.
REQ-020 SHALL, in F1, latch mem_rdata into instr[15:8], drive mem_addr=current_address+1 (mod 2^ADDR_W), mem_rd=1, next_address=current_address; go to F2.
REQ-021 SHALL, in F2, latch mem_rdata into instr[7:0], drive mem_rd=0, next_address=current_address+2 (mod 2^ADDR_W); go to EXEC.
REQ-022 SHALL, in EXEC, drive instr_valid=1, bus_grant=1, mem_rd=0, next_address=current_address while exec_done=0.
REQ-023 SHALL, in EXEC with exec_done=1, drive next_address=branch_target if branch_taken=1, else current_address.
REQ-024 SHALL, in EXEC with exec_done=1, go to HALTED if halt_req=1 (branch still applied that cycle), else to F0.
REQ-025 SHALL, in HALTED, drive next_address=current_address, mem_rd=0, bus_grant=0, instr_valid=0, halted=1; exit only by reset.
REQ-026 SHALL ignore exec_done, branch_taken, halt_req in every state except EXEC.
REQ-027 SHALL accept exec_done in the first EXEC cycle; minimum instruction period 4 cycles.
REQ-028 SHALL hold instr stable from F2 exit until the next F1 capture.
REQ-029 SHALL keep mem_rd and bus_grant mutually exclusive in every cycle.
REQ-030 SHALL wrap addresses modulo 2^ADDR_W with no error indication.

Reset
REQ-031 SHALL, while reset=1, drive next_address=0, mem_rd=0, mem_addr=0, bus_grant=0, instr_valid=0, halted=0.
REQ-032 SHALL, on a reset edge, set state=F0 and instr=0, from any state including mid-fetch or mid-EXEC.
REQ-033 SHALL abandon any in-flight fetch on reset; first post-reset read at address 0x00.

Structure
REQ-034 SHALL take the state enumeration, ADDR_W/INSTR_W defaults and RESET_PC=0x00 from shared package fetch_pkg.
REQ-035 SHALL be a single module with no sub-modules; the PC register stays a separate sibling instance.

Verification
REQ-036 Reset, memory[0x00]=0x12, [0x01]=0x34, exec_done pulsed first EXEC cycle -> instr=0x1234 in EXEC, PC=0x02, next fetch F0 at 0x02 four cycles after first.
REQ-037 exec_done with branch_taken=1, branch_target=0x40 -> PC=0x40 next edge; next mem_addr with mem_rd=1 is 0x40.
REQ-038 PC=0xFF, [0xFF]=0xAB, [0x00]=0xCD -> instr=0xABCD, PC=0x01 after F2.
REQ-039 exec_done held low 5 cycles in EXEC -> PC, instr constant, bus_grant=1, mem_rd=0 throughout; exec_done/branch_taken pulsed during F1 ignored.
REQ-040 exec_done+halt_req -> halted=1, PC frozen 20 cycles, no mem_rd; then reset -> F0 read at 0x00.
REQ-041 Reset asserted in F1 and in EXEC -> all outputs per REQ-031 that cycle; PC=0x00 and fresh fetch from 0x00 after release.
